// File: rtl/div_unit_controller_if.sv
// Issue, flush and writeback signals between the scheduler and the divider pool controller.
interface div_unit_controller_if #(
  parameter int UNIT_NUM  = 2,
  parameter int TAG_WIDTH = 7
);
  localparam int UW = $clog2(UNIT_NUM) + 1;

  logic                 issue_req;
  logic [TAG_WIDTH-1:0] issue_tag;
  logic                 issue_zero;
  logic                 flush;
  logic                 can_issue;
  logic [UNIT_NUM-1:0]  unit_start;
  logic                 result_valid;
  logic [UW-1:0]        result_unit;
  logic [TAG_WIDTH-1:0] result_tag;
  logic                 wb_ack;
  logic [UNIT_NUM-1:0]  busy_units;

  modport master (
    output issue_req, issue_tag, issue_zero, flush, wb_ack,
    input  can_issue, unit_start, result_valid, result_unit, result_tag, busy_units
  );

  modport slave (
    input  issue_req, issue_tag, issue_zero, flush, wb_ack,
    output can_issue, unit_start, result_valid, result_unit, result_tag, busy_units
  );
endinterface

// File: rtl/div_unit_controller.sv
// Issue/latency/writeback sequencing for a pool of iterative dividers.
// Optional DIV_ZERO_FAST_EN: divide-by-zero ops complete two cycles after issue.
module div_unit_controller #(
  parameter int UNIT_NUM    = 2,
  parameter int DIV_LATENCY = 34,
  parameter int TAG_WIDTH   = 7,
  parameter int CNT_WIDTH   = $clog2(DIV_LATENCY + 1)
) (
  input logic clk,
  input logic rst,
  div_unit_controller_if.slave bus
);
  localparam int UW = $clog2(UNIT_NUM) + 1;

  typedef enum logic [1:0] {FREE, BUSY, DONE, DRAIN} unitStateT;

  unitStateT            state     [UNIT_NUM];
  unitStateT            stateNext [UNIT_NUM];
  logic [CNT_WIDTH-1:0] cnt       [UNIT_NUM];
  logic [CNT_WIDTH-1:0] cntNext   [UNIT_NUM];
  logic [TAG_WIDTH-1:0] tag       [UNIT_NUM];
  logic [TAG_WIDTH-1:0] tagNext   [UNIT_NUM];

  logic [UW-1:0] rrPtr, rrPtrNext, holdUnit, holdUnitNext;
  logic [UW-1:0] freeIdx, rrSel, presUnit, idx, nextPtr;
  logic          holdValid, holdValidNext;
  logic          anyFree, anyDone, accept, resultValid, ackTake;
  logic [TAG_WIDTH-1:0] presTag;
  logic [CNT_WIDTH-1:0] loadCnt;
  logic [UNIT_NUM-1:0]  startVec, busyVec;

`ifdef DIV_ZERO_FAST_EN
  assign loadCnt = bus.issue_zero ? CNT_WIDTH'(1) : CNT_WIDTH'(DIV_LATENCY - 1);
`else
  logic unusedZero;
  assign unusedZero = bus.issue_zero;
  assign loadCnt    = CNT_WIDTH'(DIV_LATENCY - 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < UNIT_NUM; i++) begin
        state[i] <= FREE;
        cnt[i]   <= '0;
        tag[i]   <= '0;
      end
      rrPtr     <= '0;
      holdValid <= 1'b0;
      holdUnit  <= '0;
    end else begin
      for (int unsigned i = 0; i < UNIT_NUM; i++) begin
        state[i] <= stateNext[i];
        cnt[i]   <= cntNext[i];
        tag[i]   <= tagNext[i];
      end
      rrPtr     <= rrPtrNext;
      holdValid <= holdValidNext;
      holdUnit  <= holdUnitNext;
    end
  end

  // Free-unit priority pick and round-robin search over DONE units.
  always_comb begin
    anyFree = 1'b0;
    freeIdx = '0;
    anyDone = 1'b0;
    rrSel   = '0;
    idx     = '0;
    busyVec = '0;
    for (int unsigned i = 0; i < UNIT_NUM; i++) begin
      busyVec[i] = (state[i] != FREE);
      if (!anyFree && state[i] == FREE) begin
        anyFree = 1'b1;
        freeIdx = UW'(i);
      end
    end
    for (int unsigned i = 0; i < UNIT_NUM; i++) begin
      idx = rrPtr + UW'(i);
      if (idx >= UW'(UNIT_NUM)) idx = idx - UW'(UNIT_NUM);
      for (int unsigned j = 0; j < UNIT_NUM; j++) begin
        if (!anyDone && state[j] == DONE && idx == UW'(j)) begin
          anyDone = 1'b1;
          rrSel   = UW'(j);
        end
      end
    end

    presUnit = holdValid ? holdUnit : rrSel;
    presTag  = '0;
    for (int unsigned j = 0; j < UNIT_NUM; j++) begin
      if (presUnit == UW'(j)) presTag = tag[j];
    end

    resultValid = (holdValid || anyDone) && !bus.flush;
    ackTake     = resultValid && bus.wb_ack;
    accept      = bus.issue_req && anyFree && !bus.flush;

    nextPtr = presUnit + UW'(1);
    if (nextPtr >= UW'(UNIT_NUM)) nextPtr = '0;
  end

  // Per-unit next state plus the writeback hold register.
  always_comb begin
    startVec      = '0;
    rrPtrNext     = rrPtr;
    holdValidNext = holdValid;
    holdUnitNext  = holdUnit;
    for (int unsigned i = 0; i < UNIT_NUM; i++) begin
      stateNext[i] = state[i];
      cntNext[i]   = cnt[i];
      tagNext[i]   = tag[i];
      case (state[i])
        FREE: begin
          if (accept && freeIdx == UW'(i)) begin
            startVec[i]  = 1'b1;
            stateNext[i] = BUSY;
            cntNext[i]   = loadCnt;
            tagNext[i]   = bus.issue_tag;
          end
        end
        BUSY: begin
          // A flush on the final count skips DRAIN: the drain would expire on the same edge.
          if (cnt[i] == CNT_WIDTH'(1)) begin
            stateNext[i] = bus.flush ? FREE : DONE;
            cntNext[i]   = '0;
          end else begin
            cntNext[i] = cnt[i] - CNT_WIDTH'(1);
            if (bus.flush) stateNext[i] = DRAIN;
          end
        end
        DONE: begin
          if (bus.flush || (ackTake && presUnit == UW'(i))) stateNext[i] = FREE;
        end
        DRAIN: begin
          if (cnt[i] == CNT_WIDTH'(1)) begin
            stateNext[i] = FREE;
            cntNext[i]   = '0;
          end else begin
            cntNext[i] = cnt[i] - CNT_WIDTH'(1);
          end
        end
        default: stateNext[i] = FREE;
      endcase
    end

    if (bus.flush) begin
      holdValidNext = 1'b0;
    end else if (ackTake) begin
      holdValidNext = 1'b0;
      rrPtrNext     = nextPtr;
    end else if (resultValid && !holdValid) begin
      holdValidNext = 1'b1;
      holdUnitNext  = rrSel;
    end
  end

  assign bus.can_issue    = anyFree;
  assign bus.unit_start   = startVec;
  assign bus.result_valid = resultValid;
  assign bus.result_unit  = resultValid ? presUnit : '0;
  assign bus.result_tag   = resultValid ? presTag : '0;
  assign bus.busy_units   = busyVec;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.issue_req && !anyFree))
        else $warning("issue_req with no divider free; request ignored");
      for (int unsigned i = 0; i < UNIT_NUM; i++) begin
        assert (!((state[i] == BUSY || state[i] == DRAIN) && cnt[i] == '0))
          else $error("divider unit %0d counting with zero count", i);
      end
    end
  end
`endif
endmodule
